// File: rtl/ad_bus_burst_master.sv
// Burst master for the multiplexed address/data RTC bus with write/read FIFOs.
// Optional write read-back verification is enabled by defining WR_VERIFY_EN.
module ad_bus_burst_master #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16,
    parameter int PHASE_CYC = 4,
    parameter int ADDR_INC  = 1,
    localparam int CW       = $clog2(MAX_BURST) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op_wr,
    input  logic [DATA_W-1:0] base_addr,
    input  logic [CW-1:0]     burst_len,
    input  logic              wf_push,
    input  logic [DATA_W-1:0] wf_data,
    input  logic              rf_pop,
    output logic [DATA_W-1:0] rf_data,
    output logic [CW-1:0]     wf_count,
    output logic [CW-1:0]     rf_count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] ad_out,
    input  logic [DATA_W-1:0] ad_in,
    output logic              ad_oe,
    output logic              a_d,
    output logic              cs,
    output logic              rd,
    output logic              wr
`ifdef WR_VERIFY_EN
    ,
    output logic              verify_err
`endif
);

    localparam int AW = $clog2(MAX_BURST);
    localparam int PW = $clog2(PHASE_CYC + 1);
    localparam logic [CW-1:0] FULL = CW'(MAX_BURST);

    typedef enum logic [2:0] {IDLE, ADDR, GAP_A, DATA, GAP_D, FIN} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     rem_q, rem_d;
    logic              op_wr_q, op_wr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              phase_last;
    logic              vphase;
    logic [CW-1:0]     eff_len;
    logic              refuse;

    logic [DATA_W-1:0] wf_mem_q [MAX_BURST];
    logic [AW-1:0]     wf_wr_ptr_q, wf_rd_ptr_q;
    logic [CW-1:0]     wf_cnt_q;
    logic              wf_push_ok, wf_pop_ok, wf_pop_int;
    logic [DATA_W-1:0] wf_head;

    logic [DATA_W-1:0] rf_mem_q [MAX_BURST];
    logic [AW-1:0]     rf_wr_ptr_q, rf_rd_ptr_q;
    logic [CW-1:0]     rf_cnt_q;
    logic              rf_push_ok, rf_pop_ok, rf_push_int;
    logic [DATA_W-1:0] rf_last_q;

`ifdef WR_VERIFY_EN
    logic              vphase_q, vphase_d;
    logic              verr_q, verr_d;
    logic [DATA_W-1:0] wdata_q;
    assign vphase     = vphase_q;
    assign verify_err = verr_q;
`else
    assign vphase = 1'b0;
`endif

    assign wf_head    = wf_mem_q[wf_rd_ptr_q];
    assign wf_push_ok = wf_push && (wf_cnt_q != FULL);
    assign wf_pop_ok  = wf_pop_int && (wf_cnt_q != '0);
    assign wf_count   = wf_cnt_q;

    assign rf_push_ok = rf_push_int && (rf_cnt_q != FULL);
    assign rf_pop_ok  = rf_pop && (rf_cnt_q != '0);
    assign rf_count   = rf_cnt_q;
    // An empty read FIFO keeps presenting the last word the host popped
    assign rf_data    = (rf_cnt_q == '0) ? rf_last_q : rf_mem_q[rf_rd_ptr_q];

    always_ff @(posedge clk) begin
        if (wf_push_ok) wf_mem_q[wf_wr_ptr_q] <= wf_data;
        if (rf_push_ok) rf_mem_q[rf_wr_ptr_q] <= ad_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wf_wr_ptr_q <= '0;
            wf_rd_ptr_q <= '0;
            wf_cnt_q    <= '0;
            rf_wr_ptr_q <= '0;
            rf_rd_ptr_q <= '0;
            rf_cnt_q    <= '0;
            rf_last_q   <= '0;
        end else begin
            if (wf_push_ok) wf_wr_ptr_q <= wf_wr_ptr_q + AW'(1);
            if (wf_pop_ok)  wf_rd_ptr_q <= wf_rd_ptr_q + AW'(1);
            if (wf_push_ok && !wf_pop_ok)      wf_cnt_q <= wf_cnt_q + CW'(1);
            else if (!wf_push_ok && wf_pop_ok) wf_cnt_q <= wf_cnt_q - CW'(1);
            if (rf_push_ok) rf_wr_ptr_q <= rf_wr_ptr_q + AW'(1);
            if (rf_pop_ok) begin
                rf_rd_ptr_q <= rf_rd_ptr_q + AW'(1);
                rf_last_q   <= rf_mem_q[rf_rd_ptr_q];
            end
            if (rf_push_ok && !rf_pop_ok)      rf_cnt_q <= rf_cnt_q + CW'(1);
            else if (!rf_push_ok && rf_pop_ok) rf_cnt_q <= rf_cnt_q - CW'(1);
        end
    end

    assign eff_len    = (burst_len > FULL) ? FULL : burst_len;
    assign refuse     = op_wr ? (wf_cnt_q < eff_len) : ((FULL - rf_cnt_q) < eff_len);
    assign phase_last = (phase_q == PW'(PHASE_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            op_wr_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef WR_VERIFY_EN
            vphase_q <= 1'b0;
            verr_q   <= 1'b0;
            wdata_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            op_wr_q <= op_wr_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef WR_VERIFY_EN
            vphase_q <= vphase_d;
            verr_q   <= verr_d;
            if (wf_pop_ok) wdata_q <= wf_head;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        op_wr_d     = op_wr_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        wf_pop_int  = 1'b0;
        rf_push_int = 1'b0;
`ifdef WR_VERIFY_EN
        vphase_d = vphase_q;
        verr_d   = verr_q;
`endif
        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (start) begin
                    if (eff_len == '0) begin
                        state_d = FIN;
`ifdef WR_VERIFY_EN
                        verr_d = 1'b0;
`endif
                    end else if (refuse) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = base_addr;
                        rem_d   = eff_len;
                        op_wr_d = op_wr;
                        state_d = ADDR;
`ifdef WR_VERIFY_EN
                        verr_d   = 1'b0;
                        vphase_d = 1'b0;
`endif
                    end
                end
            end
            ADDR, GAP_A, DATA, GAP_D: begin
                phase_d = phase_last ? '0 : phase_q + PW'(1);
                if (phase_last) begin
                    case (state_q)
                        ADDR:  state_d = GAP_A;
                        GAP_A: state_d = DATA;
                        DATA: begin
                            state_d = GAP_D;
                            if (op_wr_q && !vphase) wf_pop_int = 1'b1;
                            if (!op_wr_q) rf_push_int = 1'b1;
`ifdef WR_VERIFY_EN
                            if (vphase_q && (ad_in != wdata_q)) verr_d = 1'b1;
`endif
                        end
                        default: begin
`ifdef WR_VERIFY_EN
                            // A written word is re-read at the same address before advancing
                            if (op_wr_q && !vphase_q) begin
                                vphase_d = 1'b1;
                                state_d  = ADDR;
                            end else begin
                                vphase_d = 1'b0;
                                rem_d    = rem_q - CW'(1);
                                addr_d   = addr_q + DATA_W'(ADDR_INC);
                                state_d  = (rem_q == CW'(1)) ? FIN : ADDR;
                            end
`else
                            rem_d   = rem_q - CW'(1);
                            addr_d  = addr_q + DATA_W'(ADDR_INC);
                            state_d = (rem_q == CW'(1)) ? FIN : ADDR;
`endif
                        end
                    endcase
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode straight from the state so an async reset idles the bus at once
    always_comb begin
        cs     = 1'b1;
        a_d    = 1'b1;
        rd     = 1'b1;
        wr     = 1'b1;
        ad_oe  = 1'b0;
        ad_out = '0;
        case (state_q)
            ADDR: begin
                cs     = 1'b0;
                a_d    = 1'b0;
                wr     = 1'b0;
                ad_oe  = 1'b1;
                ad_out = addr_q;
            end
            DATA: begin
                cs = 1'b0;
                if (op_wr_q && !vphase) begin
                    wr     = 1'b0;
                    ad_oe  = 1'b1;
                    ad_out = wf_head;
                end else begin
                    rd = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign busy = (state_q == ADDR) || (state_q == GAP_A) || (state_q == DATA) || (state_q == GAP_D);
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_ad_bus_burst_master.sv
// Directed self-checking bench for ad_bus_burst_master (default parameters).
// Covers the WR_VERIFY_EN read-back path when that macro is defined.
module tb_ad_bus_burst_master;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       op_wr = 1'b0;
    logic [7:0] base_addr = '0;
    logic [4:0] burst_len = '0;
    logic       wf_push = 1'b0;
    logic [7:0] wf_data = '0;
    logic       rf_pop = 1'b0;
    logic [7:0] rf_data;
    logic [4:0] wf_count;
    logic [4:0] rf_count;
    logic       busy, done, err;
    logic [7:0] ad_out;
    logic [7:0] ad_in;
    logic       ad_oe, a_d, cs, rd, wr;
`ifdef WR_VERIFY_EN
    logic       verify_err;
`endif

    int total = 0;
    int bad = 0;

    ad_bus_burst_master dut (
        .clk(clk), .rst(rst), .start(start), .op_wr(op_wr),
        .base_addr(base_addr), .burst_len(burst_len),
        .wf_push(wf_push), .wf_data(wf_data), .rf_pop(rf_pop), .rf_data(rf_data),
        .wf_count(wf_count), .rf_count(rf_count),
        .busy(busy), .done(done), .err(err),
        .ad_out(ad_out), .ad_in(ad_in), .ad_oe(ad_oe),
        .a_d(a_d), .cs(cs), .rd(rd), .wr(wr)
`ifdef WR_VERIFY_EN
        , .verify_err(verify_err)
`endif
    );

    always #5 clk = ~clk;

    // Bus device model: latches the address phase, stores written data, answers reads
    logic [7:0] busAddr = '0;
    logic [7:0] modelMem [256];
    int         modelMode = 0;
    logic [7:0] addrLog[$];
    logic [7:0] dataLog[$];
    int         readCnt = 0;
    int         doneCnt = 0;
    logic       inAddr, inData;
    logic       inAddrPrev = 1'b0;
    logic       inDataPrev = 1'b0;

    always @(negedge clk) begin
        inAddr = (cs == 1'b0) && (a_d == 1'b0);
        inData = (cs == 1'b0) && (a_d == 1'b1);
        if (inAddr) busAddr = ad_out;
        if (inAddr && !inAddrPrev) addrLog.push_back(ad_out);
        if (inData && !inDataPrev) begin
            if (wr == 1'b0) dataLog.push_back(ad_out);
            if (rd == 1'b0) readCnt++;
        end
        if (inData && wr == 1'b0) modelMem[busAddr] = ad_out;
        if (done === 1'b1) doneCnt++;
        inAddrPrev = inAddr;
        inDataPrev = inData;
    end

    assign ad_in = (modelMode == 0) ? busAddr + 8'h40
                                    : (modelMem[busAddr] ^ ((busAddr == 8'h05) ? 8'hFF : 8'h00));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clearLogs;
        addrLog.delete();
        dataLog.delete();
        readCnt = 0;
        doneCnt = 0;
    endtask

    task automatic pushWord(input logic [7:0] v);
        wf_push = 1'b1;
        wf_data = v;
        tick();
        wf_push = 1'b0;
    endtask

    // Returns with the sampling edge behind us, i.e. in cycle 1 after start
    task automatic startBurst(input logic w, input logic [7:0] a, input logic [4:0] len);
        start     = 1'b1;
        op_wr     = w;
        base_addr = a;
        burst_len = len;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDone(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 2000) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset;
        #2;
        total++; if ({cs, wr, rd, a_d} !== 4'b1111) begin bad++; $display("[TB] FAIL reset_strobes got=%b want=1111", {cs, wr, rd, a_d}); end
        total++; if ({ad_oe, busy, done, err} !== 4'b0000) begin bad++; $display("[TB] FAIL reset_flags got=%b want=0000", {ad_oe, busy, done, err}); end
        total++; if (ad_out !== 8'h00) begin bad++; $display("[TB] FAIL reset_ad_out got=%h want=00", ad_out); end
        total++; if ({wf_count, rf_count} !== 10'd0) begin bad++; $display("[TB] FAIL reset_counts got=%0d/%0d want=0/0", wf_count, rf_count); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write_burst;
        int cyc;
        clearLogs();
        pushWord(8'h10);
        pushWord(8'h20);
        pushWord(8'h30);
        total++; if (wf_count !== 5'd3) begin bad++; $display("[TB] FAIL wr_wf_count_pre got=%0d want=3", wf_count); end
        startBurst(1'b1, 8'h21, 5'd3);
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL wr_busy got=%b want=1", busy); end
        waitDone(cyc);
        total++; if (cyc != 50) begin bad++; $display("[TB] FAIL wr_done_cycle got=%0d want=50", cyc); end
        total++; if (addrLog.size() != 3 || addrLog[0] !== 8'h21 || addrLog[1] !== 8'h22 || addrLog[2] !== 8'h23)
            begin bad++; $display("[TB] FAIL wr_addrs got=%p want=21,22,23", addrLog); end
        total++; if (dataLog.size() != 3 || dataLog[0] !== 8'h10 || dataLog[1] !== 8'h20 || dataLog[2] !== 8'h30)
            begin bad++; $display("[TB] FAIL wr_data got=%p want=10,20,30", dataLog); end
        total++; if (wf_count !== 5'd0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL wr_post got=count%0d busy%b want=0/0", wf_count, busy); end
        tick();
    endtask

    task automatic test_read_burst;
        int cyc;
        logic [7:0] exp [3];
        exp[0] = 8'h3E; exp[1] = 8'h3F; exp[2] = 8'h40;
        clearLogs();
        modelMode = 0;
        startBurst(1'b0, 8'hFE, 5'd3);
        waitDone(cyc);
        total++; if (cyc != 50) begin bad++; $display("[TB] FAIL rd_done_cycle got=%0d want=50", cyc); end
        total++; if (addrLog.size() != 3 || addrLog[0] !== 8'hFE || addrLog[1] !== 8'hFF || addrLog[2] !== 8'h00)
            begin bad++; $display("[TB] FAIL rd_addrs got=%p want=fe,ff,00", addrLog); end
        total++; if (readCnt != 3 || dataLog.size() != 0) begin bad++; $display("[TB] FAIL rd_strobes got=%0d reads %0d writes want=3/0", readCnt, dataLog.size()); end
        total++; if (rf_count !== 5'd3) begin bad++; $display("[TB] FAIL rd_rf_count got=%0d want=3", rf_count); end
        for (int i = 0; i < 3; i++) begin
            total++; if (rf_data !== exp[i]) begin bad++; $display("[TB] FAIL rd_pop%0d got=%h want=%h", i, rf_data, exp[i]); end
            rf_pop = 1'b1;
            tick();
            rf_pop = 1'b0;
        end
        total++; if (rf_count !== 5'd0) begin bad++; $display("[TB] FAIL rd_rf_empty got=%0d want=0", rf_count); end
    endtask

    task automatic test_refusal;
        int cyc;
        pushWord(8'hAA);
        pushWord(8'hBB);
        startBurst(1'b1, 8'h00, 5'd3);
        total++; if ({err, busy, cs, wr} !== 4'b1011) begin bad++; $display("[TB] FAIL ref_wr got=err,busy,cs,wr=%b want=1011", {err, busy, cs, wr}); end
        tick();
        total++; if (err !== 1'b0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL ref_wr_pulse got=err%b busy%b want=0/0", err, busy); end
        startBurst(1'b0, 8'h00, 5'd15);
        waitDone(cyc);
        total++; if (rf_count !== 5'd15) begin bad++; $display("[TB] FAIL ref_fill got=%0d want=15", rf_count); end
        tick();
        startBurst(1'b0, 8'h00, 5'd2);
        total++; if (err !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL ref_rd got=err%b busy%b want=1/0", err, busy); end
        tick();
        startBurst(1'b0, 8'h80, 5'd1);
        total++; if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL ref_rd_fit got=err%b busy%b want=0/1", err, busy); end
        waitDone(cyc);
        total++; if (rf_count !== 5'd16) begin bad++; $display("[TB] FAIL ref_rf_full got=%0d want=16", rf_count); end
        total++; if (rf_data !== 8'h40) begin bad++; $display("[TB] FAIL ref_rf_head got=%h want=40", rf_data); end
        for (int i = 0; i < 16; i++) begin
            rf_pop = 1'b1;
            tick();
        end
        rf_pop = 1'b0;
        total++; if (rf_count !== 5'd0 || rf_data !== 8'hC0) begin bad++; $display("[TB] FAIL ref_drain got=%0d/%h want=0/c0", rf_count, rf_data); end
        rf_pop = 1'b1;
        tick();
        rf_pop = 1'b0;
        total++; if (rf_count !== 5'd0 || rf_data !== 8'hC0) begin bad++; $display("[TB] FAIL pop_empty got=%0d/%h want=0/c0", rf_count, rf_data); end
    endtask

    task automatic test_zero_len;
        clearLogs();
        startBurst(1'b1, 8'h50, 5'd0);
        total++; if ({done, busy, cs, a_d} !== 4'b0011) begin bad++; $display("[TB] FAIL zero_c1 got=%b want=0011", {done, busy, cs, a_d}); end
        tick();
        total++; if ({done, busy, cs, wr, rd} !== 5'b10111) begin bad++; $display("[TB] FAIL zero_c2 got=%b want=10111", {done, busy, cs, wr, rd}); end
        tick();
        total++; if (done !== 1'b0 || wf_count !== 5'd2 || addrLog.size() != 0) begin bad++; $display("[TB] FAIL zero_after got=done%b count%0d addrs%0d want=0/2/0", done, wf_count, addrLog.size()); end
    endtask

    task automatic test_overlong;
        int cyc;
        for (int i = 1; i <= 14; i++) pushWord(8'(i));
        total++; if (wf_count !== 5'd16) begin bad++; $display("[TB] FAIL ovl_full got=%0d want=16", wf_count); end
        pushWord(8'hEE);
        total++; if (wf_count !== 5'd16) begin bad++; $display("[TB] FAIL ovl_drop got=%0d want=16", wf_count); end
        clearLogs();
        startBurst(1'b1, 8'h30, 5'd20);
        waitDone(cyc);
        total++; if (cyc != 258) begin bad++; $display("[TB] FAIL ovl_done_cycle got=%0d want=258", cyc); end
        total++; if (dataLog.size() != 16 || addrLog.size() != 16) begin bad++; $display("[TB] FAIL ovl_accesses got=%0d/%0d want=16/16", dataLog.size(), addrLog.size()); end
        total++; if (dataLog[0] !== 8'hAA || dataLog[1] !== 8'hBB || dataLog[15] !== 8'h0E || addrLog[15] !== 8'h3F)
            begin bad++; $display("[TB] FAIL ovl_values got=%h,%h,%h @%h want=aa,bb,0e @3f", dataLog[0], dataLog[1], dataLog[15], addrLog[15]); end
        total++; if (wf_count !== 5'd0) begin bad++; $display("[TB] FAIL ovl_drain got=%0d want=0", wf_count); end
        tick();
    endtask

    task automatic test_start_while_busy;
        int cyc;
        clearLogs();
        modelMode = 0;
        startBurst(1'b0, 8'h10, 5'd1);
        repeat (3) tick();
        startBurst(1'b1, 8'h00, 5'd5);
        total++; if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("[TB] FAIL busy_start got=err%b busy%b want=0/1", err, busy); end
        waitDone(cyc);
        repeat (4) tick();
        total++; if (doneCnt != 1 || readCnt != 1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL busy_one got=done%0d reads%0d busy%b want=1/1/0", doneCnt, readCnt, busy); end
        total++; if (rf_data !== 8'h50 || rf_count !== 5'd1) begin bad++; $display("[TB] FAIL busy_data got=%h/%0d want=50/1", rf_data, rf_count); end
        rf_pop = 1'b1;
        tick();
        rf_pop = 1'b0;
    endtask

    task automatic test_reset_mid;
        int n;
        pushWord(8'h77);
        pushWord(8'h88);
        startBurst(1'b1, 8'h60, 5'd2);
        n = 0;
        while (!(cs === 1'b0 && a_d === 1'b1) && n < 100) begin
            tick();
            n++;
        end
        total++; if (n >= 100) begin bad++; $display("[TB] FAIL rstmid_reach got=timeout want=DATA phase"); end
        #2 rst = 1'b0;
        #1;
        total++; if ({cs, wr, a_d, ad_oe, busy, done} !== 6'b111000) begin bad++; $display("[TB] FAIL rstmid_bus got=%b want=111000", {cs, wr, a_d, ad_oe, busy, done}); end
        total++; if (wf_count !== 5'd0) begin bad++; $display("[TB] FAIL rstmid_wf got=%0d want=0", wf_count); end
        @(negedge clk);
        rst = 1'b1;
        doneCnt = 0;
        repeat (20) tick();
        total++; if (doneCnt != 0 || cs !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_after got=done%0d cs%b want=0/1", doneCnt, cs); end
    endtask

`ifdef WR_VERIFY_EN
    task automatic test_verify;
        int cyc;
        modelMode = 1;
        pushWord(8'h11);
        pushWord(8'h22);
        pushWord(8'h33);
        startBurst(1'b1, 8'h04, 5'd3);
        waitDone(cyc);
        total++; if (cyc != 98) begin bad++; $display("[TB] FAIL ver_done_cycle got=%0d want=98", cyc); end
        total++; if (verify_err !== 1'b1 || rf_count !== 5'd0) begin bad++; $display("[TB] FAIL ver_err got=%b rf%0d want=1/0", verify_err, rf_count); end
        tick();
        startBurst(1'b1, 8'h00, 5'd0);
        total++; if (verify_err !== 1'b0) begin bad++; $display("[TB] FAIL ver_clear got=%b want=0", verify_err); end
        tick();
        modelMode = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_refusal();
        test_zero_len();
        test_overlong();
        test_start_while_busy();
        test_reset_mid();
`ifdef WR_VERIFY_EN
        test_verify();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ad_bus_burst_master.md
Name: ad_bus_burst_master

Overview:
- Parametrised master for the multiplexed address/data RTC bus (a_d, cs, rd, wr, shared AD lines).
- Generalises the fixed per-register write/read machines into one engine. A host (PicoBlaze port logic) queues data and issues a burst of 1..MAX_BURST register accesses with auto-incrementing address.
- Phase timing is programmable. Write data and read results are buffered in FIFOs.
- Sits between the output/input register banks and the tri-state AD buffer.

Parameters:
- DATA_W, 8: width of AD bus, address, data.
- MAX_BURST, 16: max words per burst; depth of each FIFO (power of 2).
- PHASE_CYC, 4: clk cycles per bus phase (>=1).
- ADDR_INC, 1: address increment per word; 0 selects fixed-address bursts.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active low
- start  in  1  one-cycle burst request
- op_wr  in  1  1 = write burst, 0 = read burst; sampled with start
- base_addr  in  DATA_W  first register address; sampled with start
- burst_len  in  clog2(MAX_BURST)+1  words in burst; sampled with start
- wf_push  in  1  push wf_data into write FIFO
- wf_data  in  DATA_W  write data
- rf_pop  in  1  pop read FIFO
- rf_data  out  DATA_W  head of read FIFO (first-word-fall-through)
- wf_count  out  clog2(MAX_BURST)+1  write FIFO occupancy
- rf_count  out  clog2(MAX_BURST)+1  read FIFO occupancy
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion
- err  out  1  one-cycle pulse when start is refused
- ad_out  out  DATA_W  value driven onto AD
- ad_in  in  DATA_W  value sampled from AD
- ad_oe  out  1  1 = buffer drives AD
- a_d, cs, rd, wr  out  1 each  bus strobes, all active low

Behaviour:
- Reset (async, rst=0):
  - a_d, cs, rd, wr = 1; ad_oe = 0; ad_out = 0.
  - busy, done, err = 0; both FIFOs empty; state IDLE.
  - Applies immediately, including mid-burst. Partial burst is abandoned and no done pulse is produced.
- States: IDLE, ADDR, GAP_A, DATA, GAP_D, FIN. Each bus state lasts exactly PHASE_CYC cycles, counted by a phase counter.
- IDLE:
  - On start, eff_len = min(burst_len, MAX_BURST).
  - eff_len = 0: go to FIN. No bus activity; done pulses next cycle.
  - Refused, with err pulsed 1 cycle and state staying IDLE, if op_wr=1 and wf_count < eff_len, or if op_wr=0 and (MAX_BURST - rf_count) < eff_len.
  - Otherwise latch addr = base_addr, remaining = eff_len; busy=1 the next cycle; go to ADDR.
- ADDR: cs=0, a_d=0, wr=0, ad_oe=1, ad_out=addr.
- GAP_A: all strobes 1, ad_oe=0.
- DATA, write burst: cs=0, a_d=1, wr=0, ad_oe=1, ad_out = write FIFO head. The FIFO pops on the last DATA cycle.
- DATA, read burst: cs=0, a_d=1, rd=0, ad_oe=0. ad_in is pushed into the read FIFO on the last DATA cycle.
- GAP_D: all strobes 1, ad_oe=0. On its last cycle: remaining -= 1; addr = addr + ADDR_INC (mod 2^DATA_W). If remaining = 0 go to FIN, else go to ADDR.
- FIN: done=1 for 1 cycle, busy=0, go to IDLE.
- Latency: one word = 4*PHASE_CYC cycles. Burst from start to done = 1 + 4*PHASE_CYC*eff_len + 1 cycles.
- start while busy is ignored; err is not pulsed.
- FIFOs:
  - wf_push when full: dropped.
  - rf_pop when empty: ignored, and rf_data holds its last value.
  - Simultaneous push and pop on the same FIFO: both take effect; count is unchanged.
  - The host may push or pop during a burst. The admission check guarantees the burst never underflows or overflows.
- ad_oe and a strobe never change on the same edge in opposite directions. GAP states guarantee bus turnaround.

Optional Feature:
- Macro: WR_VERIFY_EN.
- Defined:
  - Each write word is followed by a read-back of the same address (extra ADDR/GAP_A/DATA(rd)/GAP_D, 4*PHASE_CYC cycles).
  - Mismatch with the written value sets output port verify_err (1 bit). It is sticky and cleared by the next accepted start or by reset.
  - Read-back data is not pushed to the read FIFO.
- Undefined: no read-back cycles, no verify_err port; write word = 4*PHASE_CYC cycles.

Test Plan:
- Reset mid-DATA of a write: assert rst=0 -> same cycle cs=wr=a_d=1, ad_oe=0, busy=0, wf_count=0, no done.
- Write burst: push 8'h10,8'h20,8'h30; start op_wr=1, base_addr=8'h21, burst_len=3, PHASE_CYC=4 -> ADDR phases carry 21,22,23, DATA phases 10,20,30. done pulses at cycle 50 after start; wf_count=0.
- Read burst: ad_in model returns addr+8'h40; start op_wr=0, base_addr=8'hFE, burst_len=3 -> addresses FE,FF,00 (wrap). rf_data pops 3E,3F,40.
- Refusal: wf_count=2, start write burst_len=3 -> err 1-cycle pulse, busy stays 0, no strobe asserted. Separately, rf_count=15 and read burst_len=2 -> err.
- burst_len=0 -> done pulse 2 cycles after start, strobes idle. burst_len=20 with MAX_BURST=16 and 16 words queued -> exactly 16 write accesses.
- WR_VERIFY_EN: model corrupts read-back of address 8'h05 -> verify_err=1 after the burst. The next accepted start clears it.
